// File: rtl/tanh_grad.sv
// tanh backward pass: dx = dy * (1 - y^2) in signed fixed point.
// Three-stage elastic pipeline with a single global stall enable.
module tanh_grad #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned FRAC   = 8
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] y,
    input  logic signed [DWIDTH-1:0] dy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DWIDTH-1:0] dx
);

    localparam int unsigned PW = 2 * DWIDTH;
    localparam int unsigned GW = DWIDTH + 1;
    localparam int unsigned MW = 2 * DWIDTH + 1;

    localparam logic [PW-1:0]        ONE_SQ = PW'(1) << FRAC;
    localparam logic signed [GW-1:0] ONE_G  = GW'(1) << FRAC;
    localparam logic signed [MW-1:0] DX_MAX = MW'({1'b0, {(DWIDTH-1){1'b1}}});
    localparam logic signed [MW-1:0] DX_MIN = ~DX_MAX;

    logic                     en;
    logic                     v1, v2;
    logic [PW-1:0]            sq1;
    logic signed [DWIDTH-1:0] dy1, dy2;
    logic signed [GW-1:0]     g2;

    logic [PW-1:0]            sq_c;
    logic [PW-1:0]            sh_c;
    logic signed [GW-1:0]     g_c;
    logic signed [MW-1:0]     p_c;
    logic signed [MW-1:0]     ps_c;
    logic signed [DWIDTH-1:0] dx_c;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // y*y is non-negative and always fits the full-width unsigned square
    assign sq_c = PW'(y) * PW'(y);
    assign sh_c = sq1 >> FRAC;

    // Compare before subtracting so large squares cannot wrap into range
    always_comb begin
        g_c = '0;
        if (sh_c < ONE_SQ) begin
            g_c = ONE_G - GW'(sh_c);
        end
    end

    assign p_c  = MW'(dy2) * MW'(g2);
    assign ps_c = p_c >>> FRAC;

    always_comb begin
        dx_c = ps_c[DWIDTH-1:0];
        if (ps_c > DX_MAX) begin
            dx_c = DWIDTH'(DX_MAX);
        end else if (ps_c < DX_MIN) begin
            dx_c = DWIDTH'(DX_MIN);
        end
    end

    // All stages advance together; a full stall freezes data and valids
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            sq1       <= '0;
            dy1       <= '0;
            dy2       <= '0;
            g2        <= '0;
            dx        <= '0;
        end else if (en) begin
            v1        <= in_valid;
            sq1       <= sq_c;
            dy1       <= dy;
            v2        <= v1;
            g2        <= g_c;
            dy2       <= dy1;
            out_valid <= v2;
            dx        <= dx_c;
        end
    end

endmodule

// File: tb/tb_tanh_grad.sv
// Self-checking bench for tanh_grad: queue scoreboard fed by the driver,
// drained by a negedge monitor, expected values from an integer model.
module tb_tanh_grad;

    localparam int DW = 16;
    localparam int FR = 8;

    logic                 clk = 1'b0;
    logic                 xrst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] y = '0;
    logic signed [DW-1:0] dy = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] dx;

    tanh_grad #(.DWIDTH(DW), .FRAC(FR)) dut (
        .clk       (clk),
        .xrst      (xrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .dy        (dy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dx        (dx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] dx;
        int                   acc;
        bit                   lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rnd_rdy = 1'b0;
    bit   rdy_fixed = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rnd_rdy ? 1'($urandom % 2) : rdy_fixed;
    end

    // Reference: dx = floor(dy * clamp(ONE - floor(y^2 / ONE), 0, ONE) / ONE), saturated
    function automatic logic signed [DW-1:0] model(input int yv, input int dyv);
        longint one = longint'(1) << FR;
        longint sq  = longint'(yv) * longint'(yv);
        longint g   = one - (sq >>> FR);
        longint p;
        longint d;
        if (g < 0) g = 0;
        if (g > one) g = one;
        p = longint'(dyv) * g;
        d = p >>> FR;
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        return DW'(d);
    endfunction

    function automatic logic signed [DW-1:0] rnd_y();
        int v;
        if ($urandom % 2 == 0) begin
            v = int'($urandom_range(600)) - 300;
            return DW'(v);
        end
        return DW'($urandom);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every output transfer and checks hold during stalls
    logic                 stall_prev = 1'b0;
    logic signed [DW-1:0] prev_dx = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!xrst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", longint'(out_valid), 1);
                    check("hold_dx", dx, prev_dx);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: dx=%0d with empty scoreboard", dx);
                    end else begin
                        e = q.pop_front();
                        check("dx", dx, e.dx);
                        // observed 3 posedge counts after acceptance = edge n+2
                        if (e.lat) check("latency", cyc - e.acc, 3);
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_dx    = dx;
            end
        end
    end

    task automatic send(input logic signed [DW-1:0] yv, input logic signed [DW-1:0] dyv,
                        input bit lat);
        int   waitc = 0;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        y        = yv;
        dy       = dyv;
        @(negedge clk);
        while (!in_ready) begin
            waitc++;
            if (waitc > 500) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready stuck at %0d", in_ready);
                return;
            end
            @(negedge clk);
        end
        e.dx  = model(int'(yv), int'(dyv));
        e.acc = cyc;
        e.lat = lat;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            y        = DW'($urandom);
            dy       = DW'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    logic signed [DW-1:0] bp_y  [6];
    logic signed [DW-1:0] bp_dy [6];

    initial begin
        int   idx;
        exp_t e;

        // Reset state
        #12;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_dx", dx, 0);
        check("rst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        xrst = 1'b1;

        // Basic points and clamps, each at latency 2
        send(16'sd0, 16'sd256, 1'b1);
        send(16'sd128, 16'sd256, 1'b1);
        send(-16'sd128, -16'sd512, 1'b1);
        send(16'sd256, 16'sd1000, 1'b1);
        send(16'sd300, 16'sd500, 1'b1);
        send(-16'sd32768, -16'sd32768, 1'b1);
        idle(1);
        drain();

        // Streaming: back-to-back pairs, results on consecutive cycles
        for (int i = 0; i < 16; i++) send(rnd_y(), DW'($urandom), 1'b1);
        idle(1);
        drain();

        // Backpressure: only three pairs fit while the output is blocked
        for (int i = 0; i < 6; i++) begin
            bp_y[i]  = rnd_y();
            bp_dy[i] = DW'($urandom);
        end
        rdy_fixed = 1'b0;
        @(posedge clk);
        #2;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            y        = bp_y[idx];
            dy       = bp_dy[idx];
            @(negedge clk);
            if (in_ready && idx < 6) begin
                e.dx  = model(int'(bp_y[idx]), int'(bp_dy[idx]));
                e.acc = cyc;
                e.lat = 1'b0;
                q.push_back(e);
                idx++;
            end
        end
        check("bp_accepted", idx, 3);
        check("bp_in_ready", longint'(in_ready), 0);
        check("bp_out_valid", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rdy_fixed = 1'b1;
        for (int i = 3; i < 6; i++) send(bp_y[i], bp_dy[i], 1'b0);
        idle(1);
        drain();

        // Random bubbles and random consumer readiness
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom % 2 == 0) idle(1);
            send(rnd_y(), DW'($urandom), 1'b0);
        end
        idle(1);
        rnd_rdy = 1'b0;
        drain();

        // Reset with three pairs in flight
        rdy_fixed = 1'b0;
        @(posedge clk);
        #2;
        send(rnd_y(), DW'($urandom), 1'b0);
        send(rnd_y(), DW'($urandom), 1'b0);
        send(rnd_y(), DW'($urandom), 1'b0);
        @(posedge clk);
        #3;
        xrst     = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_dx", dx, 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        q.delete();
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;
        xrst = 1'b1;
        send(16'sd128, 16'sd256, 1'b1);
        idle(1);
        drain();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
